// File: rtl/adc_ctrl_pkg.sv
// Shared types, defaults and helpers for the ADC conversion sequencer.
package adc_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int DEF_CONV_LAT = 12;
  localparam int DEF_DATA_W   = 9;

  // Accumulator must hold 2^avg_max_log2 full-scale samples without wrapping.
  function automatic int acc_width(input int data_w, input int avg_max_log2);
    return data_w + avg_max_log2;
  endfunction

  // Limit a requested averaging exponent to what the accumulator supports.
  function automatic int clamp_avg(input int req, input int lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Synchronous result FIFO; a push while full is only accepted together with a pop.
module adc_result_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_pop_s;
  logic              do_push_s;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify push/pop against the current occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage, power-of-two pointer wrap and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Periodic SAR ADC conversion sequencer with 2^N averaging and a result FIFO.
module adc_conv_sequencer
  import adc_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = 8,
  parameter int DIV_W        = 8,
  parameter int AVG_MAX_LOG2 = 3,
  parameter int CONV_LAT     = DEF_CONV_LAT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              start,
  input  logic [DIV_W-1:0]                  period,
  input  logic [$clog2(AVG_MAX_LOG2+1)-1:0] avg_log2,
  output logic                              conv_start,
  input  logic [DATA_W-1:0]                 adc_data_in,
  output logic [DATA_W-1:0]                 out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              overflow,
  input  logic                              clr_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int AVG_W  = $clog2(AVG_MAX_LOG2 + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ACC_W  = acc_width(DATA_W, AVG_MAX_LOG2);
  localparam int SCNT_W = AVG_MAX_LOG2 + 1;
  localparam int MIN_PER = CONV_LAT + 2;

  state_t            state_r;
  logic [DIV_W-1:0]  per_r;
  logic [AVG_W-1:0]  avg_r;
  logic              cont_r;
  logic [DIV_W-1:0]  e_r;        // cycles elapsed since the current conv_start
  logic              conv_start_r;
  logic [ACC_W-1:0]  acc_r;
  logic [SCNT_W-1:0] scnt_r;
  logic              pend_r;     // group result due to be written this cycle
  logic              new_grp_r;  // relatch configuration at the next period boundary
  logic              overflow_r;

  logic [DIV_W-1:0]  period_eff_s;
  logic [AVG_W-1:0]  avg_eff_s;
  logic [DIV_W-1:0]  e_next_s;
  logic [SCNT_W-1:0] target_s;
  logic              last_s;
  logic              abort_s;
  logic              wr_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [DATA_W-1:0] res_s;

  assign conv_start = conv_start_r;
  assign busy       = (state_r == CONV);
  assign overflow   = overflow_r;
  assign out_valid  = !empty_s;

  // Effective configuration, period phase and group bookkeeping.
  always_comb begin
    period_eff_s = period;
    if (period < DIV_W'(MIN_PER)) begin
      period_eff_s = DIV_W'(MIN_PER);
    end else begin
      period_eff_s = period;
    end
    avg_eff_s = AVG_W'(clamp_avg(int'(avg_log2), AVG_MAX_LOG2));
    e_next_s  = e_r + DIV_W'(1);
    if (e_r == (per_r - DIV_W'(1))) begin
      e_next_s = DIV_W'(0);
    end else begin
      e_next_s = e_r + DIV_W'(1);
    end
    target_s = SCNT_W'(1) << avg_r;
    last_s   = ((scnt_r + SCNT_W'(1)) == target_s);
    abort_s  = (state_r == CONV) && cont_r && !enable;
    wr_s     = pend_r && !abort_s;
    pop_s    = out_ready && !empty_s;
    res_s    = DATA_W'(acc_r >> avg_r);
  end

  // Conversion scheduling, sample accumulation and group completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      per_r        <= DIV_W'(0);
      avg_r        <= AVG_W'(0);
      cont_r       <= 1'b0;
      e_r          <= DIV_W'(0);
      conv_start_r <= 1'b0;
      acc_r        <= ACC_W'(0);
      scnt_r       <= SCNT_W'(0);
      pend_r       <= 1'b0;
      new_grp_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          conv_start_r <= 1'b0;
          pend_r       <= 1'b0;
          if (enable || start) begin
            state_r   <= CONV;
            per_r     <= period_eff_s;
            avg_r     <= avg_eff_s;
            cont_r    <= enable;
            e_r       <= period_eff_s - DIV_W'(1);
            new_grp_r <= 1'b0;
          end
        end
        CONV: begin
          if (abort_s) begin
            state_r      <= IDLE;
            conv_start_r <= 1'b0;
            acc_r        <= ACC_W'(0);
            scnt_r       <= SCNT_W'(0);
            pend_r       <= 1'b0;
            new_grp_r    <= 1'b0;
          end else begin
            e_r          <= e_next_s;
            conv_start_r <= (e_next_s == DIV_W'(0));
            pend_r       <= 1'b0;
            if (e_r == DIV_W'(CONV_LAT)) begin
              acc_r  <= acc_r + ACC_W'(adc_data_in);
              scnt_r <= scnt_r + SCNT_W'(1);
              pend_r <= last_s;
            end
            if (pend_r) begin
              acc_r  <= ACC_W'(0);
              scnt_r <= SCNT_W'(0);
              if (!cont_r) begin
                state_r      <= IDLE;
                conv_start_r <= 1'b0;
              end else begin
                new_grp_r <= 1'b1;
              end
            end
            if ((e_next_s == DIV_W'(0)) && (pend_r || new_grp_r)) begin
              per_r     <= period_eff_s;
              avg_r     <= avg_eff_s;
              new_grp_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          conv_start_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped result sets it, and a drop beats a clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (wr_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  adc_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_s),
    .push_data (res_s),
    .pop       (pop_s),
    .head      (out_data),
    .full      (full_s),
    .empty     (empty_s),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed scenario bench for adc_conv_sequencer with a simple ADC slice model.
module tb_adc_conv_sequencer;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       start;
  logic [7:0] period;
  logic [1:0] avg_log2;
  logic       conv_start;
  logic [8:0] adc_data_in;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overflow;
  logic       clr_overflow;
  logic [3:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] samp_q[$];
  logic [8:0] samp_def = 9'd0;
  int         conv_t[$];

  adc_conv_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .period       (period),
    .avg_log2     (avg_log2),
    .conv_start   (conv_start),
    .adc_data_in  (adc_data_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .fifo_count   (fifo_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  // ADC slice model: each conv_start presents the next sample, held until the next start.
  initial begin
    adc_data_in = 9'd0;
    forever begin
      @(negedge clock);
      if (conv_start === 1'b1) begin
        conv_t.push_back(cyc);
        if (samp_q.size() > 0) adc_data_in = samp_q.pop_front();
        else adc_data_in = samp_def;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    n_vec++; if (conv_start !== 1'b0) begin n_err++; $display("FAIL reset_conv_start got %0b exp 0", conv_start); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_vec++; if (out_data !== 9'd0) begin n_err++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_single_shot();
    period = 8'd20; avg_log2 = 2'd0; samp_def = 9'h0A5;
    conv_t.delete();
    start = 1'b1;                  // cycle 0
    step(1); start = 1'b0;         // cycle 1
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ss_busy_c1 got %0b exp 1", busy); end
    n_vec++; if (conv_start !== 1'b0) begin n_err++; $display("FAIL ss_cs_c1 got %0b exp 0", conv_start); end
    step(1);                       // cycle 2
    n_vec++; if (conv_start !== 1'b1) begin n_err++; $display("FAIL ss_cs_c2 got %0b exp 1", conv_start); end
    step(13);                      // cycle 15
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ss_valid_c15 got %0b exp 0", out_valid); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ss_busy_c15 got %0b exp 1", busy); end
    step(1);                       // cycle 16
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ss_valid_c16 got %0b exp 1", out_valid); end
    n_vec++; if (out_data !== 9'h0A5) begin n_err++; $display("FAIL ss_data got %0h exp a5", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ss_busy_c16 got %0b exp 0", busy); end
    step(30);
    n_vec++; if (conv_t.size() !== 1) begin n_err++; $display("FAIL ss_conv_count got %0d exp 1", conv_t.size()); end
    pop_one();
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL ss_popped_count got %0d exp 0", fifo_count); end
  endtask

  task automatic test_continuous_avg();
    period = 8'd20; avg_log2 = 2'd2; samp_def = 9'd0;
    samp_q = '{9'd100, 9'd101, 9'd102, 9'd104};
    conv_t.delete();
    enable = 1'b1;
    for (int i = 0; i < 300 && out_valid !== 1'b1; i++) step(1);
    enable = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL cont_timeout got %0b exp 1", out_valid); end
    n_vec++; if (out_data !== 9'd101) begin n_err++; $display("FAIL cont_avg got %0d exp 101", out_data); end
    n_vec++; if (conv_t.size() !== 4) begin n_err++; $display("FAIL cont_conv_count got %0d exp 4", conv_t.size()); end
    if (conv_t.size() >= 4) begin
      n_vec++; if (conv_t[1] - conv_t[0] !== 20) begin n_err++; $display("FAIL cont_spacing got %0d exp 20", conv_t[1] - conv_t[0]); end
      n_vec++; if (conv_t[3] - conv_t[0] !== 60) begin n_err++; $display("FAIL cont_span got %0d exp 60", conv_t[3] - conv_t[0]); end
    end
    step(3);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_stop_busy got %0b exp 0", busy); end
    pop_one();
  endtask

  task automatic test_min_period();
    period = 8'd3; avg_log2 = 2'd3; samp_def = 9'd0;
    samp_q = '{9'd10, 9'd20, 9'd30, 9'd40, 9'd50, 9'd60, 9'd70, 9'd81};
    conv_t.delete();
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 300 && out_valid !== 1'b1; i++) step(1);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL minp_timeout got %0b exp 1", out_valid); end
    n_vec++; if (out_data !== 9'd45) begin n_err++; $display("FAIL minp_avg8 got %0d exp 45", out_data); end
    n_vec++; if (conv_t.size() !== 8) begin n_err++; $display("FAIL minp_conv_count got %0d exp 8", conv_t.size()); end
    if (conv_t.size() >= 8) begin
      n_vec++; if (conv_t[1] - conv_t[0] !== 14) begin n_err++; $display("FAIL minp_spacing got %0d exp 14", conv_t[1] - conv_t[0]); end
      n_vec++; if (conv_t[7] - conv_t[0] !== 98) begin n_err++; $display("FAIL minp_span got %0d exp 98", conv_t[7] - conv_t[0]); end
    end
    step(20);
    n_vec++; if (conv_t.size() !== 8) begin n_err++; $display("FAIL minp_no_extra got %0d exp 8", conv_t.size()); end
    pop_one();
  endtask

  task automatic test_overflow();
    period = 8'd14; avg_log2 = 2'd0; samp_def = 9'h1FF;
    samp_q = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8, 9'd9};
    out_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 400 && fifo_count !== 4'd8; i++) step(1);
    n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf_fill got %0d exp 8", fifo_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %0b exp 0", overflow); end
    for (int i = 0; i < 40 && overflow !== 1'b1; i++) step(1);
    enable = 1'b0;
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got %0b exp 1", overflow); end
    n_vec++; if (out_data !== 9'd1) begin n_err++; $display("FAIL ovf_head got %0d exp 1", out_data); end
    n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d exp 8", fifo_count); end
    step(2);
    clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
  endtask

  task automatic test_full_write_pop();
    period = 8'd20; avg_log2 = 2'd0;
    samp_q.delete(); samp_q.push_back(9'd9);
    start = 1'b1;                  // cycle 0, FIFO holds 1..8
    step(1); start = 1'b0;
    step(1);                       // cycle 2
    n_vec++; if (conv_start !== 1'b1) begin n_err++; $display("FAIL fwp_cs got %0b exp 1", conv_start); end
    step(13);                      // cycle 15: result written at this cycle's edge
    out_ready = 1'b1;
    step(1); out_ready = 1'b0;     // cycle 16
    n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL fwp_count got %0d exp 8", fifo_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fwp_overflow got %0b exp 0", overflow); end
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (out_data !== 9'(k + 2)) begin n_err++; $display("FAIL fwp_order%0d got %0d exp %0d", k, out_data, k + 2); end
      pop_one();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fwp_drained got %0b exp 0", out_valid); end
  endtask

  task automatic test_enable_drop();
    period = 8'd20; avg_log2 = 2'd2; samp_def = 9'd0;
    samp_q = '{9'd50, 9'd60};
    enable = 1'b1;                 // cycle 0
    step(40);                      // two captures done (cycles 14, 34)
    enable = 1'b0;
    step(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy got %0b exp 0", busy); end
    step(60);
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL drop_partial got %0d exp 0", fifo_count); end
    avg_log2 = 2'd0;
    samp_q.delete(); samp_q.push_back(9'd77);
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 100 && out_valid !== 1'b1; i++) step(1);
    n_vec++; if (out_data !== 9'd77) begin n_err++; $display("FAIL drop_single got %0d exp 77", out_data); end
    n_vec++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL drop_single_count got %0d exp 1", fifo_count); end
  endtask

  task automatic test_reset_mid();
    period = 8'd14; avg_log2 = 2'd0; samp_def = 9'h055;
    enable = 1'b1;
    for (int i = 0; i < 200 && fifo_count < 4'd3; i++) step(1);
    n_vec++; if (fifo_count < 4'd3) begin n_err++; $display("FAIL rmid_fill got %0d exp 3", fifo_count); end
    reset = 1'b1; enable = 1'b0;
    step(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %0b exp 0", busy); end
    n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rmid_count got %0d exp 0", fifo_count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %0b exp 0", out_valid); end
    n_vec++; if (out_data !== 9'd0) begin n_err++; $display("FAIL rmid_data got %0h exp 0", out_data); end
    n_vec++; if (conv_start !== 1'b0) begin n_err++; $display("FAIL rmid_cs got %0b exp 0", conv_start); end
    reset = 1'b0;
    conv_t.delete();
    step(40);
    n_vec++; if (conv_t.size() !== 0) begin n_err++; $display("FAIL rmid_no_conv got %0d exp 0", conv_t.size()); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; period = 8'd20;
    avg_log2 = 2'd0; out_ready = 1'b0; clr_overflow = 1'b0;
    step(1);
    test_reset();
    test_single_shot();
    test_continuous_avg();
    test_min_period();
    test_overflow();
    test_full_write_pop();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
